// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer
// Receive-side GMII frame extractor. It registers the PCS/PMA byte stream,
// strips the preamble and SFD, checks and strips the CRC-32 FCS, and emits
// the payload as a byte-wide AXI4-Stream with no tready.
// tuser on the tlast beat flags a bad frame. Saturating statistics counters
// report good frames, bad frames and CRC errors.
// The over-length cut assumes MAX_FRAME >= 5, so a beat is always due when
// the byte count reaches MAX_FRAME+1.
module gmii_rx_framer #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter int CNT_W     = 32
) (
   input  logic             userclk2,
   input  logic             sys0_rst,
   input  logic [7:0]       gmii_rxd,
   input  logic             gmii_rx_dv,
   input  logic             gmii_rx_er,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   output logic             m_axis_tuser,
   output logic [CNT_W-1:0] stat_good,
   output logic [CNT_W-1:0] stat_bad,
   output logic [CNT_W-1:0] stat_crc_err
);

   localparam int LEN_W = $clog2(MAX_FRAME + 2);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_FIVE = LEN_W'(5);
   localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_FRAME);
   localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [7:0]       BYTE_PRE = 8'h55;
   localparam logic [7:0]       BYTE_SFD = 8'hD5;

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   // One byte of reflected CRC-32 (poly 0xEDB88320), LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
         else                c = c >> 1;
      end
      return c;
   endfunction

   logic [7:0]       rxd_q;
   logic             dv_q, er_q;
   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [31:0]      crc_q, crc_d;
   logic             err_q, err_d;
   logic             shift_en;
   logic [7:0]       dly_q [0:4];
   logic [7:0]       tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
   logic             good_inc_q, good_inc_d, bad_inc_q, bad_inc_d, crc_inc_q, crc_inc_d;
   logic [CNT_W-1:0] stat_good_q, stat_bad_q, stat_crc_q;
   logic             crc_bad, frame_bad;

   // Register the GMII inputs once before any decoding.
   always_ff @(posedge userclk2 or posedge sys0_rst) begin
      if (sys0_rst) begin
         rxd_q <= 8'h00;
         dv_q  <= 1'b0;
         er_q  <= 1'b0;
      end else begin
         rxd_q <= gmii_rxd;
         dv_q  <= gmii_rx_dv;
         er_q  <= gmii_rx_er;
      end
   end

   // Delay line head: the newest frame byte enters stage 0.
   always_ff @(posedge userclk2 or posedge sys0_rst) begin
      if (sys0_rst)      dly_q[0] <= 8'h00;
      else if (shift_en) dly_q[0] <= rxd_q;
   end

   // Remaining delay stages; stage 4 holds the oldest byte, the next beat.
   genvar gi;
   generate
      for (gi = 1; gi < 5; gi++) begin : g_dly
         // Shift one stage down the line on every accepted frame byte.
         always_ff @(posedge userclk2 or posedge sys0_rst) begin
            if (sys0_rst)      dly_q[gi] <= 8'h00;
            else if (shift_en) dly_q[gi] <= dly_q[gi-1];
         end
      end
   endgenerate

   // Next-state, CRC/length tracking and output beat selection.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      crc_d      = crc_q;
      err_d      = err_q;
      shift_en   = 1'b0;
      tdata_d    = tdata_q;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      tuser_d    = 1'b0;
      good_inc_d = 1'b0;
      bad_inc_d  = 1'b0;
      crc_inc_d  = 1'b0;
      crc_bad    = (crc_q != CRC_RESIDUE);
      frame_bad  = crc_bad | err_q | (len_q < LEN_MIN);
      case (state_q)
         S_IDLE, S_PRE: begin
            if (!dv_q) begin
               // Carrier dropped during the preamble counts as a bad frame.
               if (state_q == S_PRE) begin
                  state_d   = S_IDLE;
                  bad_inc_d = 1'b1;
               end
            end else if (rxd_q == BYTE_PRE) begin
               state_d = S_PRE;
            end else if (rxd_q == BYTE_SFD) begin
               // SFD restarts the delay line (via len) and the CRC.
               state_d = S_DATA;
               len_d   = '0;
               crc_d   = CRC_INIT;
               err_d   = 1'b0;
            end else begin
               state_d   = S_DROP;
               bad_inc_d = 1'b1;
            end
         end
         S_DATA: begin
            if (dv_q) begin
               shift_en = 1'b1;
               crc_d    = crc32_byte(crc_q, rxd_q);
               len_d    = len_q + LEN_ONE;
               err_d    = err_q | er_q;
               if (len_q >= LEN_FIVE) begin
                  tvalid_d = 1'b1;
                  tdata_d  = dly_q[4];
               end
               // This byte makes the frame MAX_FRAME+1 long: cut it here.
               if (len_q == LEN_MAX) begin
                  tlast_d   = 1'b1;
                  tuser_d   = 1'b1;
                  bad_inc_d = 1'b1;
                  state_d   = S_DROP;
               end
            end else begin
               state_d   = S_IDLE;
               crc_inc_d = crc_bad;
               if (len_q >= LEN_FIVE) begin
                  tvalid_d   = 1'b1;
                  tlast_d    = 1'b1;
                  tdata_d    = dly_q[4];
                  tuser_d    = frame_bad;
                  good_inc_d = ~frame_bad;
                  bad_inc_d  = frame_bad;
               end else begin
                  bad_inc_d = 1'b1;
               end
            end
         end
         S_DROP: begin
            if (!dv_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state, frame tracking and the registered AXI-Stream beat.
   always_ff @(posedge userclk2 or posedge sys0_rst) begin
      if (sys0_rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         crc_q      <= CRC_INIT;
         err_q      <= 1'b0;
         tdata_q    <= 8'h00;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tuser_q    <= 1'b0;
         good_inc_q <= 1'b0;
         bad_inc_q  <= 1'b0;
         crc_inc_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         crc_q      <= crc_d;
         err_q      <= err_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tuser_q    <= tuser_d;
         good_inc_q <= good_inc_d;
         bad_inc_q  <= bad_inc_d;
         crc_inc_q  <= crc_inc_d;
      end
   end

   // Saturating statistics, updated the cycle after the frame's tlast beat.
   always_ff @(posedge userclk2 or posedge sys0_rst) begin
      if (sys0_rst) begin
         stat_good_q <= '0;
         stat_bad_q  <= '0;
         stat_crc_q  <= '0;
      end else begin
         if (good_inc_q && (stat_good_q != '1)) stat_good_q <= stat_good_q + CNT_W'(1);
         if (bad_inc_q  && (stat_bad_q  != '1)) stat_bad_q  <= stat_bad_q  + CNT_W'(1);
         if (crc_inc_q  && (stat_crc_q  != '1)) stat_crc_q  <= stat_crc_q  + CNT_W'(1);
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign stat_good     = stat_good_q;
   assign stat_bad      = stat_bad_q;
   assign stat_crc_err  = stat_crc_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed testbench for gmii_rx_framer: builds frames with a bench-side
// CRC-32, drives them on GMII and checks beats, flags, latency and counters.
module tb_gmii_rx_framer;

   logic        userclk2 = 1'b0;
   logic        sys0_rst = 1'b1;
   logic [7:0]  gmii_rxd = 8'h00;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
   logic [31:0] stat_good, stat_bad, stat_crc_err;

   gmii_rx_framer dut (
      .userclk2(userclk2), .sys0_rst(sys0_rst),
      .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .stat_good(stat_good), .stat_bad(stat_bad), .stat_crc_err(stat_crc_err)
   );

   always #4 userclk2 = ~userclk2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int dv0_cyc  = 0;
   int b5_cyc   = 0;
   int exp_good = 0, exp_bad = 0, exp_crc = 0;

   // Monitor state (cumulative; tests take snapshots)
   logic [7:0] rx_q [$];
   int         cyc_q [$];
   int         beat_total = 0, last_total = 0, last_beat_idx = 0, tlast_cyc = 0;
   logic       last_user = 1'b0;

   logic [7:0] frame_q [$];

   always @(posedge userclk2) cyc <= cyc + 1;

   always @(negedge userclk2) begin
      if (m_axis_tvalid === 1'b1) begin
         rx_q.push_back(m_axis_tdata);
         cyc_q.push_back(cyc);
         beat_total = beat_total + 1;
         if (m_axis_tlast === 1'b1) begin
            last_total    = last_total + 1;
            last_beat_idx = beat_total;
            last_user     = m_axis_tuser;
            tlast_cyc     = cyc;
         end
      end
   end

   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'h0, b};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Payload i = 5*i+1 (never 0x55/0xD5 in the first 60 bytes), then FCS LSB first.
   task automatic build_frame(input int n_pay);
      logic [31:0] c;
      logic [7:0]  b;
      frame_q.delete();
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n_pay; i++) begin
         b = 8'((i * 5 + 1) & 255);
         frame_q.push_back(b);
         c = crc_step(c, b);
      end
      c = ~c;
      frame_q.push_back(c[7:0]);
      frame_q.push_back(c[15:8]);
      frame_q.push_back(c[23:16]);
      frame_q.push_back(c[31:24]);
   endtask

   function automatic int count_mm(input int start, input int n);
      int m;
      m = 0;
      for (int i = 0; i < n; i++) begin
         if (start + i >= rx_q.size()) m++;
         else if (rx_q[start + i] !== frame_q[i]) m++;
      end
      return m;
   endfunction

   task automatic drive(input logic dv, input logic [7:0] d, input logic er);
      @(negedge userclk2);
      gmii_rx_dv = dv;
      gmii_rxd   = d;
      gmii_rx_er = er;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0);
   endtask

   // Preamble, SFD, frame_q (rx_er on byte er_idx), then one dv=0 cycle.
   task automatic send_frame(input int er_idx);
      repeat (7) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < frame_q.size(); i++) begin
         drive(1'b1, frame_q[i], (i == er_idx));
         if (i == 5) b5_cyc = cyc;
      end
      drive(1'b0, 8'h00, 1'b0);
      dv0_cyc = cyc;
   endtask

   task automatic test_reset;
      idle(3);
      n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
      n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
      n_checks++; if (m_axis_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser got %b want 0", m_axis_tuser); end
      n_checks++; if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got %h want 00", m_axis_tdata); end
      n_checks++; if (stat_good !== 32'd0) begin n_fail++; $display("FAIL reset_good got %0d want 0", stat_good); end
      n_checks++; if (stat_bad !== 32'd0) begin n_fail++; $display("FAIL reset_bad got %0d want 0", stat_bad); end
      n_checks++; if (stat_crc_err !== 32'd0) begin n_fail++; $display("FAIL reset_crc got %0d want 0", stat_crc_err); end
      @(negedge userclk2);
      sys0_rst = 1'b0;
      idle(2);
      $display("test_reset done");
   endtask

   task automatic test_good_frame;
      int b0, l0;
      b0 = beat_total; l0 = last_total;
      build_frame(60);
      send_frame(-1);
      idle(6);
      exp_good++;
      n_checks++; if (beat_total - b0 !== 60) begin n_fail++; $display("FAIL good_beats got %0d want 60", beat_total - b0); end
      n_checks++; if (last_total - l0 !== 1) begin n_fail++; $display("FAIL good_tlasts got %0d want 1", last_total - l0); end
      n_checks++; if (last_beat_idx - b0 !== 60) begin n_fail++; $display("FAIL good_tlast_pos got %0d want 60", last_beat_idx - b0); end
      n_checks++; if (last_user !== 1'b0) begin n_fail++; $display("FAIL good_tuser got %b want 0", last_user); end
      n_checks++; if (count_mm(b0, 60) !== 0) begin n_fail++; $display("FAIL good_data mismatches got %0d want 0", count_mm(b0, 60)); end
      n_checks++; if (tlast_cyc - dv0_cyc !== 2) begin n_fail++; $display("FAIL good_tlast_latency got %0d want 2", tlast_cyc - dv0_cyc); end
      n_checks++; if (cyc_q.size() <= b0 || cyc_q[b0] - b5_cyc !== 2) begin n_fail++; $display("FAIL good_beat_latency got %0d want 2", (cyc_q.size() > b0) ? cyc_q[b0] - b5_cyc : -1); end
      n_checks++; if (stat_good !== 32'(exp_good)) begin n_fail++; $display("FAIL good_stat_good got %0d want %0d", stat_good, exp_good); end
      n_checks++; if (stat_bad !== 32'(exp_bad)) begin n_fail++; $display("FAIL good_stat_bad got %0d want %0d", stat_bad, exp_bad); end
      $display("good frame: %0d beats, tuser=%b, good=%0d bad=%0d", beat_total - b0, last_user, stat_good, stat_bad);
   endtask

   task automatic test_crc_error;
      int b0;
      b0 = beat_total;
      build_frame(60);
      frame_q[10][0] = ~frame_q[10][0];
      send_frame(-1);
      idle(6);
      exp_bad++; exp_crc++;
      n_checks++; if (beat_total - b0 !== 60) begin n_fail++; $display("FAIL crc_beats got %0d want 60", beat_total - b0); end
      n_checks++; if (last_user !== 1'b1) begin n_fail++; $display("FAIL crc_tuser got %b want 1", last_user); end
      n_checks++; if (count_mm(b0, 60) !== 0) begin n_fail++; $display("FAIL crc_data mismatches got %0d want 0", count_mm(b0, 60)); end
      n_checks++; if (stat_crc_err !== 32'(exp_crc)) begin n_fail++; $display("FAIL crc_stat_crc got %0d want %0d", stat_crc_err, exp_crc); end
      n_checks++; if (stat_bad !== 32'(exp_bad)) begin n_fail++; $display("FAIL crc_stat_bad got %0d want %0d", stat_bad, exp_bad); end
      n_checks++; if (stat_good !== 32'(exp_good)) begin n_fail++; $display("FAIL crc_stat_good got %0d want %0d", stat_good, exp_good); end
      $display("crc error frame: %0d beats, tuser=%b, crc_err=%0d", beat_total - b0, last_user, stat_crc_err);
   endtask

   task automatic test_rx_er;
      int b0;
      b0 = beat_total;
      build_frame(60);
      send_frame(20);
      idle(6);
      exp_bad++;
      n_checks++; if (beat_total - b0 !== 60) begin n_fail++; $display("FAIL rxer_beats got %0d want 60", beat_total - b0); end
      n_checks++; if (last_user !== 1'b1) begin n_fail++; $display("FAIL rxer_tuser got %b want 1", last_user); end
      n_checks++; if (stat_bad !== 32'(exp_bad)) begin n_fail++; $display("FAIL rxer_stat_bad got %0d want %0d", stat_bad, exp_bad); end
      n_checks++; if (stat_crc_err !== 32'(exp_crc)) begin n_fail++; $display("FAIL rxer_stat_crc got %0d want %0d", stat_crc_err, exp_crc); end
      $display("rx_er frame: tuser=%b, bad=%0d crc_err=%0d", last_user, stat_bad, stat_crc_err);
      b0 = beat_total;
      drive(1'b0, 8'h0F, 1'b1);
      idle(6);
      n_checks++; if (beat_total - b0 !== 0) begin n_fail++; $display("FAIL ext_beats got %0d want 0", beat_total - b0); end
      n_checks++; if (stat_good !== 32'(exp_good) || stat_bad !== 32'(exp_bad) || stat_crc_err !== 32'(exp_crc))
         begin n_fail++; $display("FAIL ext_counters got %0d/%0d/%0d want %0d/%0d/%0d", stat_good, stat_bad, stat_crc_err, exp_good, exp_bad, exp_crc); end
      $display("rx_er with dv=0: counters %0d/%0d/%0d", stat_good, stat_bad, stat_crc_err);
   endtask

   task automatic test_oversize;
      int b0, l0;
      b0 = beat_total; l0 = last_total;
      build_frame(1519);
      send_frame(-1);
      idle(6);
      exp_bad++;
      n_checks++; if (beat_total - b0 !== 1514) begin n_fail++; $display("FAIL long_beats got %0d want 1514", beat_total - b0); end
      n_checks++; if (last_total - l0 !== 1) begin n_fail++; $display("FAIL long_tlasts got %0d want 1", last_total - l0); end
      n_checks++; if (last_beat_idx - b0 !== 1514) begin n_fail++; $display("FAIL long_tlast_pos got %0d want 1514", last_beat_idx - b0); end
      n_checks++; if (last_user !== 1'b1) begin n_fail++; $display("FAIL long_tuser got %b want 1", last_user); end
      n_checks++; if (count_mm(b0, 1514) !== 0) begin n_fail++; $display("FAIL long_data mismatches got %0d want 0", count_mm(b0, 1514)); end
      n_checks++; if (stat_bad !== 32'(exp_bad)) begin n_fail++; $display("FAIL long_stat_bad got %0d want %0d", stat_bad, exp_bad); end
      n_checks++; if (stat_crc_err !== 32'(exp_crc)) begin n_fail++; $display("FAIL long_stat_crc got %0d want %0d", stat_crc_err, exp_crc); end
      $display("oversize frame: %0d beats, tuser=%b, bad=%0d", beat_total - b0, last_user, stat_bad);
   endtask

   task automatic test_back_to_back;
      int b0, l0;
      b0 = beat_total;
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h54, 1'b0);
      repeat (10) drive(1'b1, 8'hD5, 1'b0);
      idle(6);
      exp_bad++;
      n_checks++; if (beat_total - b0 !== 0) begin n_fail++; $display("FAIL prebad_beats got %0d want 0", beat_total - b0); end
      n_checks++; if (stat_bad !== 32'(exp_bad)) begin n_fail++; $display("FAIL prebad_stat_bad got %0d want %0d", stat_bad, exp_bad); end
      $display("bad preamble: beats=%0d bad=%0d", beat_total - b0, stat_bad);
      b0 = beat_total; l0 = last_total;
      build_frame(60);
      send_frame(-1);
      send_frame(-1);
      idle(6);
      exp_good += 2;
      n_checks++; if (beat_total - b0 !== 120) begin n_fail++; $display("FAIL b2b_beats got %0d want 120", beat_total - b0); end
      n_checks++; if (last_total - l0 !== 2) begin n_fail++; $display("FAIL b2b_tlasts got %0d want 2", last_total - l0); end
      n_checks++; if (count_mm(b0, 60) + count_mm(b0 + 60, 60) !== 0) begin n_fail++; $display("FAIL b2b_data mismatches got %0d want 0", count_mm(b0, 60) + count_mm(b0 + 60, 60)); end
      n_checks++; if (stat_good !== 32'(exp_good)) begin n_fail++; $display("FAIL b2b_stat_good got %0d want %0d", stat_good, exp_good); end
      $display("back-to-back: %0d beats, good=%0d", beat_total - b0, stat_good);
   endtask

   task automatic test_reset_midframe;
      int l0, b0;
      build_frame(60);
      repeat (7) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < 30; i++) drive(1'b1, frame_q[i], 1'b0);
      n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_streaming got %b want 1", m_axis_tvalid); end
      l0 = last_total;
      drive(1'b1, frame_q[30], 1'b0);
      sys0_rst = 1'b1;
      #1;
      n_checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'h00)
         begin n_fail++; $display("FAIL midrst_outputs got v=%b l=%b d=%h want 0/0/00", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
      drive(1'b1, frame_q[31], 1'b0);
      drive(1'b1, frame_q[32], 1'b0);
      sys0_rst = 1'b0;
      exp_good = 0; exp_bad = 1; exp_crc = 0;
      for (int i = 33; i < frame_q.size(); i++) drive(1'b1, frame_q[i], 1'b0);
      idle(6);
      n_checks++; if (last_total - l0 !== 0) begin n_fail++; $display("FAIL midrst_tlasts got %0d want 0", last_total - l0); end
      n_checks++; if (stat_bad !== 32'(exp_bad)) begin n_fail++; $display("FAIL midrst_stat_bad got %0d want %0d", stat_bad, exp_bad); end
      n_checks++; if (stat_good !== 32'(exp_good)) begin n_fail++; $display("FAIL midrst_stat_good got %0d want %0d", stat_good, exp_good); end
      $display("reset mid-frame: bad=%0d good=%0d", stat_bad, stat_good);
      b0 = beat_total;
      send_frame(-1);
      idle(6);
      exp_good++;
      n_checks++; if (beat_total - b0 !== 60) begin n_fail++; $display("FAIL postrst_beats got %0d want 60", beat_total - b0); end
      n_checks++; if (stat_good !== 32'(exp_good)) begin n_fail++; $display("FAIL postrst_stat_good got %0d want %0d", stat_good, exp_good); end
      $display("frame after reset: beats=%0d good=%0d", beat_total - b0, stat_good);
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_crc_error;
      test_rx_er;
      test_oversize;
      test_back_to_back;
      test_reset_midframe;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
